// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch front end. Issues one outstanding read at a time to the
// instruction memory, buffers returned words with their addresses in a 2-entry
// FIFO, and presents the head entry to decode. A redirect (taken branch/jump)
// flushes the FIFO and restarts fetch at redirect_pc; a response still in
// flight at that moment is discarded when it arrives.
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | no request outstanding; issues at PC when FIFO has room
// WAIT  | request outstanding, response will be kept
// DROP  | request outstanding, response will be discarded (post-redirect)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   imem_req / imem_addr     read request and its address
//   imem_ack / imem_rdata    read response
//   redirect / redirect_pc   fetch restart from decode/execute
//   id_valid / id_ready      head-entry handshake with decode
//   id_instr / id_pc         head entry (zero when empty)
//   id_opcode                id_instr[31:26]
//   perf_fetched/perf_dropped  (only with FETCH_STATS_EN) push / discard counts
//
// Build option: define FETCH_STATS_EN to add the performance counters.
//------------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
`ifdef FETCH_STATS_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped,
`endif
  output logic [5:0]  id_opcode
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] infl_q, infl_d;

  logic [31:0] fifo_instr [0:1];
  logic [31:0] fifo_pc    [0:1];
  logic        head_q, tail_q;
  logic [1:0]  count_q;

  logic        req;
  logic [31:0] addr;
  logic        push;
  logic [31:0] push_pc;
  logic        flush;
  logic        pop;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    infl_d  = infl_q;
    req     = 1'b0;
    addr    = pc_q;
    push    = 1'b0;
    push_pc = pc_q;
    flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          flush = 1'b1;
          pc_d  = redirect_pc;
        end else if (count_q < 2'd2) begin
          req    = 1'b1;
          infl_d = pc_q;
          if (imem_ack) begin
            push = 1'b1;
            pc_d = pc_q + 32'd4;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        req     = 1'b1;
        addr    = infl_q;
        push_pc = infl_q;
        if (redirect) begin
          flush   = 1'b1;
          pc_d    = redirect_pc;
          state_d = imem_ack ? ST_IDLE : ST_DROP;
        end else if (imem_ack) begin
          push    = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        req  = 1'b1;
        addr = infl_q;
        if (redirect) begin
          flush = 1'b1;
          pc_d  = redirect_pc;
        end
        if (imem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request is suppressed during the reset cycle itself, so a stray ack then
  // cannot be mistaken for a response.
  assign imem_req  = req && !rst;
  assign imem_addr = addr;

  assign id_valid  = (count_q != 2'd0);
  // Redirect wins over a same-cycle pop: the flush clears the entry anyway.
  assign pop       = id_valid && id_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      infl_q  <= RESET_PC;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      infl_q  <= infl_d;
      if (flush) begin
        head_q  <= 1'b0;
        tail_q  <= 1'b0;
        count_q <= 2'd0;
      end else begin
        if (push) tail_q <= ~tail_q;
        if (pop)  head_q <= ~head_q;
        case ({push, pop})
          2'b10:   count_q <= count_q + 2'd1;
          2'b01:   count_q <= count_q - 2'd1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (!rst && push && !flush) begin
      fifo_instr[tail_q] <= imem_rdata;
      fifo_pc[tail_q]    <= push_pc;
    end
  end

  assign id_instr  = id_valid ? fifo_instr[head_q] : 32'h0;
  assign id_pc     = id_valid ? fifo_pc[head_q]    : 32'h0;
  assign id_opcode = id_instr[31:26];

`ifdef FETCH_STATS_EN
  // A response consumed without a push is one thrown away after a redirect.
  logic resp_dropped;
  assign resp_dropped = imem_req && imem_ack && !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 32'd0;
      perf_dropped <= 32'd0;
    end else begin
      if (push)         perf_fetched <= perf_fetched + 32'd1;
      if (resp_dropped) perf_dropped <= perf_dropped + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_ack, redirect, id_ready;
  logic [31:0] redirect_pc;

  logic        imem_req, id_valid;
  logic [31:0] imem_addr, imem_rdata, id_instr, id_pc;
  logic [5:0]  id_opcode;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;
  logic [5:0]  w_opcode;
`ifdef FETCH_STATS_EN
  logic [31:0] perf_fetched, perf_dropped, w_perf_fetched, w_perf_dropped;
`endif

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc),
`ifdef FETCH_STATS_EN
    .perf_fetched(perf_fetched), .perf_dropped(perf_dropped),
`endif
    .id_opcode(id_opcode)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(w_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .id_valid(w_valid),
    .id_instr(w_instr), .id_pc(w_pc),
`ifdef FETCH_STATS_EN
    .perf_fetched(w_perf_fetched), .perf_dropped(w_perf_dropped),
`endif
    .id_opcode(w_opcode)
  );

  // Instruction memory contents: fixed word at 0, scrambled address elsewhere.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  assign imem_rdata = mem_fn(imem_addr);
  assign w_rdata    = mem_fn(w_addr);

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the instruction stream decode must see, in order.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] gen_pc;

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: gen_pc, instr: mem_fn(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    gen_pc = start;
    topup();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    restart_stream(32'h0);
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] a);
    redirect    = 1'b1;
    redirect_pc = a;
    restart_stream(a);
  endtask

  // Monitor
  exp_t        mon_e;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_rst = 1'b1;
  logic [31:0] prev_addr = 32'h0;

  always @(negedge clk) begin
    if (!rst && !redirect && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stream_underflow: got pc %h expected no entry", id_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("stream_pc", id_pc, mon_e.pc);
        chk("stream_instr", id_instr, mon_e.instr);
        chk("stream_opcode", 32'(id_opcode), 32'(mon_e.instr[31:26]));
        n_acc++;
      end
    end
    if (!rst && !id_valid) begin
      chk("empty_pc", id_pc, 32'h0);
      chk("empty_instr", id_instr, 32'h0);
    end
    if (prev_req && !prev_ack && !prev_rst && !rst) begin
      chk("hold_req", 32'(imem_req), 32'd1);
      chk("hold_addr", imem_addr, prev_addr);
    end
    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_rst  = rst;
    prev_addr = imem_addr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b1; redirect = 1'b0; id_ready = 1'b1;
    redirect_pc = 32'h0;
    restart_stream(32'h0);
    repeat (2) cyc();

    // Reset state
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    rst = 1'b0;

    // Zero-wait streaming, plus wrap from 0xFFFFFFFC on the second instance
    #1;
    chk("zw_req1", 32'(imem_req), 32'd1);
    chk("zw_addr1", imem_addr, 32'h0);
    chk("zw_valid1", 32'(id_valid), 32'd0);
    chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
    cyc(); #1;
    chk("zw_addr2", imem_addr, 32'h4);
    chk("zw_valid2", 32'(id_valid), 32'd1);
    chk("zw_pc2", id_pc, 32'h0);
    chk("opcode_addi", 32'(id_opcode), 32'(6'b001000));
    chk("wrap_addr2", w_addr, 32'h0);
    cyc(); #1;
    chk("zw_addr3", imem_addr, 32'h8);
    chk("zw_pc3", id_pc, 32'h4);

    // Decode stalled: FIFO fills to two, then issue stops
    do_reset();
    id_ready = 1'b0; imem_ack = 1'b1;
    #1;
    chk("full_addr1", imem_addr, 32'h0);
    cyc(); #1;
    chk("full_addr2", imem_addr, 32'h4);
    cyc(); #1;
    chk("full_req3", 32'(imem_req), 32'd0);
    cyc(); #1;
    chk("full_req4", 32'(imem_req), 32'd0);
    cyc(); id_ready = 1'b1; #1;
    chk("full_req5", 32'(imem_req), 32'd0);
    chk("full_pc5", id_pc, 32'h0);
    cyc(); #1;
    chk("resume_req", 32'(imem_req), 32'd1);
    chk("resume_addr", imem_addr, 32'h8);
    chk("resume_pc", id_pc, 32'h4);

    // Ack delayed by three cycles
    do_reset();
    imem_ack = 1'b0; id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) imem_ack = 1'b1;
      #1;
      chk("slow_addr", imem_addr, 32'h0);
      cyc();
    end
    imem_ack = 1'b0; #1;
    chk("slow_valid", 32'(id_valid), 32'd1);
    chk("slow_pc", id_pc, 32'h0);
    chk("slow_idle_addr", imem_addr, 32'h4);

    // Redirect while waiting: in-flight response discarded
    do_reset();
    imem_ack = 1'b0; id_ready = 1'b1;
    #1;
    chk("rd_addr1", imem_addr, 32'h0);
    cyc(); do_redirect(32'h100); #1;
    chk("rd_addr2", imem_addr, 32'h0);
    cyc(); redirect = 1'b0; #1;
    chk("rd_drop_req", 32'(imem_req), 32'd1);
    chk("rd_drop_addr", imem_addr, 32'h0);
    cyc(); imem_ack = 1'b1; #1;
    cyc(); imem_ack = 1'b0; #1;
    chk("rd_empty", 32'(id_valid), 32'd0);
    chk("rd_new_addr", imem_addr, 32'h100);
`ifdef FETCH_STATS_EN
    chk("rd_perf_dropped", perf_dropped, 32'd1);
    chk("rd_perf_fetched", perf_fetched, 32'd0);
`endif
    imem_ack = 1'b1;
    cyc(); #1;
    chk("rd_new_pc", id_pc, 32'h100);

    // Randomized traffic
    n_acc = 0;
    for (int c = 0; c < 3000; c++) begin
      int mode;
      logic [31:0] a;
      mode = (c / 500) % 3;
      if ($urandom_range(299) == 0) do_reset();
      redirect = 1'b0;
      if ($urandom_range(15) == 0) begin
        a = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
        do_redirect(a);
      end
      if (mode == 0)      imem_ack = 1'b1;
      else if (mode == 1) imem_ack = 1'($urandom_range(1));
      else                imem_ack = ($urandom_range(4) == 0);
      id_ready = ($urandom_range(9) < 7);
      cyc();
    end
    redirect = 1'b0;
    chk("progress", 32'(n_acc >= 300), 32'd1);

    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
